rf_write_scheduler: RTL

Arbitrates the single write port of the 32×32 register file between two producers: the ALU writeback path (`wb`) and the load-return path (`ld`). It uses round-robin grant, a registered write stage and x0 suppression. Optionally it keeps a per-register pending scoreboard, and the decode stage queries it for read-after-write stalls. Its outputs drive the register file's `rd`/`DataWr`/`RFWr` inputs directly.

---
 rtl/rf_write_scheduler_if.sv | 24 ++
 rtl/rf_write_scheduler.sv | 106 ++++++++++
 2 files changed

// File: rtl/rf_write_scheduler_if.sv
// Producer-side request bundle for rf_write_scheduler: ALU writeback (wb) and load return (ld).
interface rf_write_scheduler_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;

  modport master (
    output wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data,
    input  wb_ready, ld_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data,
    output wb_ready, ld_ready
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Round-robin arbiter for the register-file write port with a registered write stage.
// Optional pending scoreboard for RAW stalls, enabled by defining RF_SCOREBOARD_EN.
module rf_write_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  rf_write_scheduler_if.slave  req,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        chk_rs1,
  input  logic [AW-1:0]        chk_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 stall
);

  typedef enum logic {GrWb, GrLd} grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            grant_wb, grant_ld, accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            rf_we_q;
  logic [AW-1:0]   rf_rd_q;
  logic [XLEN-1:0] rf_wdata_q;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_wb     = req.wb_valid && (!req.ld_valid || last_grant_q == GrLd);
    grant_ld     = req.ld_valid && !grant_wb;
    accept       = grant_wb || grant_ld;
    sel_rd       = grant_wb ? req.wb_rd   : req.ld_rd;
    sel_data     = grant_wb ? req.wb_data : req.ld_data;
    req.wb_ready = grant_wb && RST_N;
    req.ld_ready = grant_ld && RST_N;
    last_grant_d = last_grant_q;
    if (grant_wb) begin
      last_grant_d = GrWb;
    end else if (grant_ld) begin
      last_grant_d = GrLd;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= GrLd;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      if (accept) begin
        // x0 writes consume the grant but never reach the register file.
        rf_we_q    <= (sel_rd != '0);
        rf_rd_q    <= sel_rd;
        rf_wdata_q <= sel_data;
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] pending_q, pending_d;

  // Clear first, then set, so a fresh issue survives a commit to the same register.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      pending_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy = pending_q[chk_rs1] && (chk_rs1 != '0);
  assign rs2_busy = pending_q[chk_rs2] && (chk_rs2 != '0);
  assign stall    = rs1_busy || rs2_busy;
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid, issue_rd, chk_rs1, chk_rs2};
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
  assign stall    = 1'b0;
`endif

endmodule
